// File: rtl/vrased_reset_seq_pkg.sv
// Shared types for the VRASED violation reset sequencer.
// State codes, log source codes and the log entry layout.
package vrased_reset_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HOLD    = 2'd1,
        S_CLEAR   = 2'd2,
        S_RELEASE = 2'd3
    } state_e;

    localparam logic [1:0] SRC_PC   = 2'b00;
    localparam logic [1:0] SRC_DATA = 2'b01;
    localparam logic [1:0] SRC_DMA  = 2'b10;
    localparam logic [1:0] SRC_BOTH = 2'b11;

    localparam int LOG_W = 34;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] addr;
        logic [1:0]  src;
    } log_entry_t;

    function automatic log_entry_t make_entry(
        input logic [15:0] pc,
        input logic        data_en,
        input logic [15:0] data_addr,
        input logic        dma_en,
        input logic [15:0] dma_addr
    );
        log_entry_t e;
        e.pc   = pc;
        e.addr = data_en ? data_addr : (dma_en ? dma_addr : 16'h0000);
        e.src  = {dma_en, data_en};
        return e;
    endfunction

endpackage

// File: rtl/vrased_reset_seq_if.sv
// Bus between the VRASED monitor / CPU side and the reset sequencer.
// master drives violation, history and log pops; slave is the sequencer.
interface vrased_reset_seq_if;
    logic        vrased_reset;
    logic [15:0] pc;
    logic        data_en;
    logic [15:0] data_addr;
    logic        dma_en;
    logic [15:0] dma_addr;
    logic        sys_reset;
    logic        clr_ram;
    logic        busy;
    logic        log_rd;
    logic        log_valid;
    logic [15:0] log_pc;
    logic [15:0] log_addr;
    logic [1:0]  log_src;
    logic        log_ovf;
    logic [7:0]  viol_cnt;

    modport master (
        output vrased_reset, pc, data_en, data_addr,
        output dma_en, dma_addr, log_rd,
        input  sys_reset, clr_ram, busy, log_valid,
        input  log_pc, log_addr, log_src, log_ovf, viol_cnt
    );

    modport slave (
        input  vrased_reset, pc, data_en, data_addr,
        input  dma_en, dma_addr, log_rd,
        output sys_reset, clr_ram, busy, log_valid,
        output log_pc, log_addr, log_src, log_ovf, viol_cnt
    );
endinterface

// File: rtl/vrased_reset_seq_log_fifo.sv
// Synchronous first-word-fall-through FIFO for violation log entries.
// A pop frees a slot in the same cycle, so push+pop on full is accepted.
module vrased_log_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q;
    logic [AW:0]  rd_q;
    logic         do_push;
    logic         do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= data_i;
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/vrased_reset_seq.sv
// Turns each VRASED violation reset into hold / RAM-clear / release,
// logging the offending access from the one-cycle-old history registers.
module vrased_reset_seq
    import vrased_reset_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 8,
    parameter int CLR_CYCLES  = 2,
    parameter int LOG_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset,
    vrased_reset_seq_if.slave   bus
);
    localparam int CMAX = (HOLD_CYCLES > CLR_CYCLES) ? HOLD_CYCLES : CLR_CYCLES;
    localparam int CW   = ($clog2(CMAX) > 0) ? $clog2(CMAX) : 1;

    state_e      state_q;
    logic [CW-1:0] cnt_q;
    logic        sys_reset_q;
    logic        clr_ram_q;
    logic        busy_q;
    logic        log_ovf_q;
    logic [7:0]  viol_cnt_q;

    logic [15:0] h_pc_q;
    logic        h_data_en_q;
    logic [15:0] h_data_addr_q;
    logic        h_dma_en_q;
    logic [15:0] h_dma_addr_q;

    logic        push;
    logic        full;
    logic        empty;
    log_entry_t  entry;
    log_entry_t  head;

    assign push  = (state_q == S_IDLE) && bus.vrased_reset;
    assign entry = make_entry(h_pc_q, h_data_en_q, h_data_addr_q,
                              h_dma_en_q, h_dma_addr_q);

    vrased_log_fifo #(
        .W     (LOG_W),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (entry),
        .pop_i   (bus.log_rd),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            h_pc_q        <= '0;
            h_data_en_q   <= 1'b0;
            h_data_addr_q <= '0;
            h_dma_en_q    <= 1'b0;
            h_dma_addr_q  <= '0;
        end else begin
            h_pc_q        <= bus.pc;
            h_data_en_q   <= bus.data_en;
            h_data_addr_q <= bus.data_addr;
            h_dma_en_q    <= bus.dma_en;
            h_dma_addr_q  <= bus.dma_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_CLEAR;
            cnt_q       <= '0;
            sys_reset_q <= 1'b1;
            clr_ram_q   <= 1'b0;
            busy_q      <= 1'b1;
            log_ovf_q   <= 1'b0;
            viol_cnt_q  <= '0;
        end else begin
            if (push && full && !bus.log_rd) begin
                log_ovf_q <= 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    clr_ram_q <= 1'b0;
                    if (bus.vrased_reset) begin
                        state_q     <= S_HOLD;
                        cnt_q       <= '0;
                        sys_reset_q <= 1'b1;
                        busy_q      <= 1'b1;
                        if (viol_cnt_q != 8'hFF) begin
                            viol_cnt_q <= viol_cnt_q + 8'd1;
                        end
                    end else begin
                        sys_reset_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                S_HOLD: begin
                    sys_reset_q <= 1'b1;
                    busy_q      <= 1'b1;
                    if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                        state_q   <= S_CLEAR;
                        cnt_q     <= '0;
                        clr_ram_q <= 1'b1;
                    end else begin
                        cnt_q     <= cnt_q + CW'(1);
                        clr_ram_q <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    sys_reset_q <= 1'b1;
                    busy_q      <= 1'b1;
                    clr_ram_q   <= 1'b1;
                    // Coming out of power-on reset the strobe is not yet up;
                    // counting starts once it is, so it always lasts CLR_CYCLES.
                    if (clr_ram_q) begin
                        if (cnt_q == CW'(CLR_CYCLES - 1)) begin
                            state_q   <= S_RELEASE;
                            cnt_q     <= '0;
                            clr_ram_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                S_RELEASE: begin
                    clr_ram_q <= 1'b0;
                    if (bus.vrased_reset) begin
                        sys_reset_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end else begin
                        state_q     <= S_IDLE;
                        sys_reset_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.sys_reset = sys_reset_q;
    assign bus.clr_ram   = clr_ram_q;
    assign bus.busy      = busy_q;
    assign bus.log_valid = !empty;
    assign bus.log_pc    = head.pc;
    assign bus.log_addr  = head.addr;
    assign bus.log_src   = head.src;
    assign bus.log_ovf   = log_ovf_q;
    assign bus.viol_cnt  = viol_cnt_q;
endmodule

// File: tb/tb_vrased_reset_seq.sv
// Directed bench for the VRASED reset sequencer.
module tb_vrased_reset_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    vrased_reset_seq_if bus();

    vrased_reset_seq #(
        .HOLD_CYCLES (8),
        .CLR_CYCLES  (2),
        .LOG_DEPTH   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        bit done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            step();
            if (!bus.busy) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout busy=%0b required=0", tag, bus.busy);
        end
    endtask

    // Drives the access now, then the violation one cycle later with
    // different live values; returns just after the capture edge.
    task automatic violate(input logic [15:0] p, input logic den,
                           input logic [15:0] da, input logic men,
                           input logic [15:0] ma);
        bus.pc = p; bus.data_en = den; bus.data_addr = da;
        bus.dma_en = men; bus.dma_addr = ma;
        step();
        bus.pc = 16'hFFFF; bus.data_en = 1'b0; bus.data_addr = 16'hBEEF;
        bus.dma_en = 1'b0; bus.dma_addr = 16'hCAFE;
        bus.vrased_reset = 1'b1;
        step();
        bus.vrased_reset = 1'b0;
    endtask

    task automatic pop_one();
        bus.log_rd = 1'b1;
        step();
        bus.log_rd = 1'b0;
    endtask

    task automatic power_on(input string tag);
        int c = 0;
        int s = 0;
        bit done = 0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            if (bus.clr_ram) c++;
            if (bus.sys_reset) s++;
            if (!bus.busy) done = 1;
        end
        checks++;
        if (c != 2) begin
            errors++;
            $display("FAIL %s_clr_cycles got=%0d required=2", tag, c);
        end
        checks++;
        if (s != 3) begin
            errors++;
            $display("FAIL %s_sys_cycles got=%0d required=3", tag, s);
        end
        checks++;
        if (bus.sys_reset !== 1'b0 || bus.log_valid !== 1'b0 || bus.viol_cnt !== 8'd0) begin
            errors++;
            $display("FAIL %s_idle sys=%0b valid=%0b cnt=%0d required=0/0/0",
                     tag, bus.sys_reset, bus.log_valid, bus.viol_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({bus.sys_reset, bus.clr_ram, bus.busy} !== 3'b101) begin
            errors++;
            $display("FAIL reset_ctrl got=%b required=101",
                     {bus.sys_reset, bus.clr_ram, bus.busy});
        end
        checks++;
        if ({bus.log_valid, bus.log_ovf} !== 2'b00 || bus.viol_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_log valid=%0b ovf=%0b cnt=%0d required=0/0/0",
                     bus.log_valid, bus.log_ovf, bus.viol_cnt);
        end
        power_on("poweron");
    endtask

    task automatic test_cpu_access();
        int s = 1;
        int c = 0;
        bit done = 0;
        violate(16'h0000, 1'b1, 16'h0440, 1'b0, 16'h0000);
        checks++;
        if (bus.sys_reset !== 1'b1 || bus.viol_cnt !== 8'd1) begin
            errors++;
            $display("FAIL cpu_start sys=%0b cnt=%0d required=1/1",
                     bus.sys_reset, bus.viol_cnt);
        end
        checks++;
        if (bus.log_valid !== 1'b1 || bus.log_pc !== 16'h0000 ||
            bus.log_addr !== 16'h0440 || bus.log_src !== 2'b01) begin
            errors++;
            $display("FAIL cpu_entry v=%0b pc=%h addr=%h src=%b required=1/0000/0440/01",
                     bus.log_valid, bus.log_pc, bus.log_addr, bus.log_src);
        end
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            if (bus.clr_ram && !bus.sys_reset) begin
                errors++;
                $display("FAIL cpu_clr_without_sys clr=1 sys=0 required sys=1");
            end
            if (bus.sys_reset) s++;
            else done = 1;
            if (bus.clr_ram) c++;
        end
        checks++;
        if (s != 11) begin
            errors++;
            $display("FAIL cpu_sys_cycles got=%0d required=11", s);
        end
        checks++;
        if (c != 2) begin
            errors++;
            $display("FAIL cpu_clr_cycles got=%0d required=2", c);
        end
    endtask

    task automatic test_dma_access();
        violate(16'h1234, 1'b0, 16'h0000, 1'b1, 16'h6A00);
        step();
        // pop while the CPU is held in reset
        checks++;
        if (bus.sys_reset !== 1'b1) begin
            errors++;
            $display("FAIL dma_pop_in_reset sys=%0b required=1", bus.sys_reset);
        end
        pop_one();
        bus.vrased_reset = 1'b1;
        step();
        bus.vrased_reset = 1'b0;
        wait_idle("dma");
        checks++;
        if (bus.viol_cnt !== 8'd2) begin
            errors++;
            $display("FAIL dma_cnt got=%0d required=2", bus.viol_cnt);
        end
        checks++;
        if (bus.log_valid !== 1'b1 || bus.log_pc !== 16'h1234 ||
            bus.log_addr !== 16'h6A00 || bus.log_src !== 2'b10) begin
            errors++;
            $display("FAIL dma_entry v=%0b pc=%h addr=%h src=%b required=1/1234/6A00/10",
                     bus.log_valid, bus.log_pc, bus.log_addr, bus.log_src);
        end
        pop_one();
        checks++;
        if (bus.log_valid !== 1'b0) begin
            errors++;
            $display("FAIL dma_no_extra_entry valid=%0b required=0", bus.log_valid);
        end
    endtask

    task automatic test_atomicity();
        bus.pc = 16'hA000; bus.data_en = 1'b0; bus.dma_en = 1'b0;
        step();
        bus.pc = 16'h0002;
        bus.vrased_reset = 1'b1;
        step();
        checks++;
        if (bus.log_pc !== 16'hA000 || bus.log_addr !== 16'h0000 ||
            bus.log_src !== 2'b00 || bus.viol_cnt !== 8'd3) begin
            errors++;
            $display("FAIL atom_entry pc=%h addr=%h src=%b cnt=%0d required=A000/0000/00/3",
                     bus.log_pc, bus.log_addr, bus.log_src, bus.viol_cnt);
        end
        repeat (19) step();
        checks++;
        if ({bus.sys_reset, bus.busy, bus.clr_ram} !== 3'b110) begin
            errors++;
            $display("FAIL atom_release_hold got=%b required=110",
                     {bus.sys_reset, bus.busy, bus.clr_ram});
        end
        bus.vrased_reset = 1'b0;
        step();
        checks++;
        if ({bus.sys_reset, bus.busy} !== 2'b00 || bus.viol_cnt !== 8'd3) begin
            errors++;
            $display("FAIL atom_exit sys=%0b busy=%0b cnt=%0d required=0/0/3",
                     bus.sys_reset, bus.busy, bus.viol_cnt);
        end
        pop_one();
    endtask

    task automatic test_overflow();
        power_on("ovf_reset");
        for (int i = 0; i < 5; i++) begin
            violate(16'h1000 + 16'(i), 1'b1, 16'h0200 + 16'(i), 1'b0, 16'h0);
            wait_idle("ovf_fill");
        end
        checks++;
        if (bus.log_valid !== 1'b1 || bus.log_ovf !== 1'b1 || bus.viol_cnt !== 8'd5) begin
            errors++;
            $display("FAIL ovf_flags v=%0b ovf=%0b cnt=%0d required=1/1/5",
                     bus.log_valid, bus.log_ovf, bus.viol_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.log_pc !== 16'h1000 + 16'(i) ||
                bus.log_addr !== 16'h0200 + 16'(i) || bus.log_src !== 2'b01) begin
                errors++;
                $display("FAIL ovf_order%0d pc=%h addr=%h src=%b required=%h/%h/01",
                         i, bus.log_pc, bus.log_addr, bus.log_src,
                         16'h1000 + 16'(i), 16'h0200 + 16'(i));
            end
            pop_one();
        end
        checks++;
        if (bus.log_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_fifth_absent valid=%0b required=0", bus.log_valid);
        end
    endtask

    task automatic test_back_to_back();
        power_on("b2b_reset");
        for (int i = 0; i < 4; i++) begin
            violate(16'h2000 + 16'(i), 1'b1, 16'h0300 + 16'(i), 1'b1, 16'h7000);
            wait_idle("b2b_fill");
        end
        bus.pc = 16'h2004; bus.data_en = 1'b0;
        bus.dma_en = 1'b1; bus.dma_addr = 16'h7004;
        step();
        bus.dma_en = 1'b0;
        bus.vrased_reset = 1'b1;
        bus.log_rd = 1'b1;
        step();
        bus.vrased_reset = 1'b0;
        bus.log_rd = 1'b0;
        wait_idle("b2b");
        checks++;
        if (bus.log_ovf !== 1'b0 || bus.viol_cnt !== 8'd5) begin
            errors++;
            $display("FAIL b2b_no_ovf ovf=%0b cnt=%0d required=0/5",
                     bus.log_ovf, bus.viol_cnt);
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (bus.log_pc !== 16'h2000 + 16'(i) ||
                bus.log_addr !== 16'h0300 + 16'(i) || bus.log_src !== 2'b11) begin
                errors++;
                $display("FAIL b2b_entry%0d pc=%h addr=%h src=%b required=%h/%h/11",
                         i, bus.log_pc, bus.log_addr, bus.log_src,
                         16'h2000 + 16'(i), 16'h0300 + 16'(i));
            end
            pop_one();
        end
        checks++;
        if (bus.log_valid !== 1'b1 || bus.log_pc !== 16'h2004 ||
            bus.log_addr !== 16'h7004 || bus.log_src !== 2'b10) begin
            errors++;
            $display("FAIL b2b_last v=%0b pc=%h addr=%h src=%b required=1/2004/7004/10",
                     bus.log_valid, bus.log_pc, bus.log_addr, bus.log_src);
        end
        pop_one();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 252; i++) begin
            violate(16'h3000, 1'b0, 16'h0, 1'b0, 16'h0);
            wait_idle("sat");
        end
        checks++;
        if (bus.viol_cnt !== 8'd255 || bus.log_ovf !== 1'b1) begin
            errors++;
            $display("FAIL sat_cnt cnt=%0d ovf=%0b required=255/1",
                     bus.viol_cnt, bus.log_ovf);
        end
    endtask

    task automatic test_reset_in_clear();
        bit seen = 0;
        violate(16'h4444, 1'b1, 16'h0555, 1'b0, 16'h0);
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.clr_ram) seen = 1;
            else step();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL midclr_reach clr=%0b required=1", bus.clr_ram);
        end
        reset = 1'b1;
        step();
        checks++;
        if ({bus.sys_reset, bus.clr_ram, bus.busy, bus.log_valid, bus.log_ovf} !== 5'b10100 ||
            bus.viol_cnt !== 8'd0) begin
            errors++;
            $display("FAIL midclr_reset got=%b cnt=%0d required=10100/0",
                     {bus.sys_reset, bus.clr_ram, bus.busy, bus.log_valid, bus.log_ovf},
                     bus.viol_cnt);
        end
        power_on("midclr_rerun");
    endtask

    initial begin
        bus.vrased_reset = 1'b0;
        bus.pc = '0; bus.data_en = 1'b0; bus.data_addr = '0;
        bus.dma_en = 1'b0; bus.dma_addr = '0;
        bus.log_rd = 1'b0;
        test_reset();
        test_cpu_access();
        test_dma_access();
        test_atomicity();
        test_overflow();
        test_saturate();
        test_back_to_back();
        test_reset_in_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
